// File: rtl/reduce_ingress_buffer.sv
// Ingress buffer in front of the reduce unit. Router flits go through one capture stage (S1).
// Each reduce flit is tagged with the number of children this node waits on in the reduction
// tree rooted at the flit's rank. Tagged entries are queued in a first-word-fall-through FIFO.
// A flit that arrives while the FIFO is full is dropped, and a sticky overflow flag records it.
module reduce_ingress_buffer #(
  parameter int unsigned MyRank        = 0,
  parameter int unsigned lg_numprocs   = 3,
  parameter int unsigned PayloadWidth  = 32,
  parameter int unsigned lg_depth      = 4,
  localparam int unsigned FlitWidth     = PayloadWidth + 50,
  localparam int unsigned ChildrenWidth = lg_numprocs,
  localparam int unsigned EntryWidth    = FlitWidth + ChildrenWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FlitWidth-1:0]  flit_in,
  input  logic                  wr_en,
  output logic                  in_ready,
  input  logic                  rd_en,
  output logic [EntryWidth-1:0] dout,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic [12:0]           fifo_counter,
  output logic                  overflow
);

  localparam int unsigned Depth    = 1 << lg_depth;
  localparam int unsigned CntWidth = lg_depth + 1;
  localparam int unsigned OpPos    = PayloadWidth;
  localparam int unsigned RankPos  = PayloadWidth + 22;

  localparam logic [CntWidth-1:0]      DepthCnt    = CntWidth'(Depth);
  localparam logic [CntWidth-1:0]      ReadyMaxCnt = CntWidth'(Depth - 2);
  localparam logic [ChildrenWidth-1:0] MyRankBits  = ChildrenWidth'(MyRank);
  localparam logic [ChildrenWidth-1:0] RootChildren = ChildrenWidth'(lg_numprocs);

  // Capture stage
  logic                 s1_valid_q;
  logic [FlitWidth-1:0] s1_flit_q;

  // Tree decode of the S1 flit
  logic [3:0]               s1_op;
  logic                     s1_is_reduce;
  logic [ChildrenWidth-1:0] s1_root;
  logic [ChildrenWidth-1:0] s1_rel;
  logic [ChildrenWidth-1:0] s1_children;

  // FIFO state
  logic [EntryWidth-1:0] mem_q [Depth];
  logic [lg_depth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [lg_depth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;

  // S1 valid: only strobed flits that carry their valid bit enter the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= wr_en & flit_in[FlitWidth-1];
    end
  end

  // S1 payload register; the contents only matter while s1_valid_q is set
  always_ff @(posedge clk) begin
    if (wr_en) begin
      s1_flit_q <= flit_in;
    end
  end

  assign s1_op        = s1_flit_q[OpPos +: 4];
  assign s1_is_reduce = (s1_op[3:2] == 2'b11);
  assign s1_root      = s1_flit_q[RankPos +: ChildrenWidth];
  // Modular subtraction falls out of the ChildrenWidth-bit wrap
  assign s1_rel       = MyRankBits - s1_root;

  // Children count: the root waits on lg_numprocs children, others on trailing zeros of rel
  always_comb begin
    s1_children = '0;
    if (s1_is_reduce) begin
      if (s1_rel == '0) begin
        s1_children = RootChildren;
      end else begin
        // Scan downward so the lowest set bit wins
        for (int i = ChildrenWidth - 1; i >= 0; i--) begin
          if (s1_rel[i]) begin
            s1_children = ChildrenWidth'(i);
          end
        end
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);

  // Fullness is judged at the start of the cycle; a pop in the same cycle does not rescue the flit
  assign push = s1_valid_q & ~fifo_full;
  assign drop = s1_valid_q & fifo_full;
  assign pop  = rd_en & ~fifo_empty;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset wins over any strobe in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array, not reset; stale entries are unreachable once the pointers are cleared
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= {s1_children, s1_flit_q};
    end
  end

  assign dout         = mem_q[rd_ptr_q];
  assign buf_empty    = fifo_empty;
  assign buf_full     = fifo_full;
  assign fifo_counter = 13'(count_q);
  assign overflow     = overflow_q;
  // Two slots of headroom cover the strobe already sitting in S1 plus the next one
  assign in_ready     = (count_q <= ReadyMaxCnt);

endmodule

// File: tb/tb_reduce_ingress_buffer.sv
// Directed bench for reduce_ingress_buffer. Two instances share the stimulus: one at rank 0 and
// one at rank 6, so the children tagging can be checked against two different tree positions.
module tb_reduce_ingress_buffer;

  localparam int unsigned FW = 82;
  localparam int unsigned EW = 85;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] flit_in;
  logic          wr_en;
  logic          rd_en;

  logic          in_ready0, buf_empty0, buf_full0, overflow0;
  logic [EW-1:0] dout0;
  logic [12:0]   count0;
  logic          in_ready6, buf_empty6, buf_full6, overflow6;
  logic [EW-1:0] dout6;
  logic [12:0]   count6;

  int checks = 0;
  int errors = 0;

  reduce_ingress_buffer #(.MyRank(0)) dut0 (
    .clk(clk), .rst(rst), .flit_in(flit_in), .wr_en(wr_en), .in_ready(in_ready0),
    .rd_en(rd_en), .dout(dout0), .buf_empty(buf_empty0), .buf_full(buf_full0),
    .fifo_counter(count0), .overflow(overflow0)
  );

  reduce_ingress_buffer #(.MyRank(6)) dut6 (
    .clk(clk), .rst(rst), .flit_in(flit_in), .wr_en(wr_en), .in_ready(in_ready6),
    .rd_en(rd_en), .dout(dout6), .buf_empty(buf_empty6), .buf_full(buf_full6),
    .fifo_counter(count6), .overflow(overflow6)
  );

  always #5 clk = ~clk;

  // valid at 81, rank at 56:54, op at 35:32, payload at 31:0; filler bits exercise full width
  function automatic logic [FW-1:0] mk_flit(input logic v, input logic [3:0] op,
                                            input logic [2:0] rank, input logic [31:0] payload);
    logic [FW-1:0] f;
    f         = '0;
    f[81]     = v;
    f[80:57]  = 24'hC3C35A ^ payload[23:0];
    f[56:54]  = rank;
    f[53:36]  = payload[17:0];
    f[35:32]  = op;
    f[31:0]   = payload;
    return f;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      flit_in = mk_flit(1'b1, 4'b0001, 3'd1, 32'(i));
      wr_en   = 1'b1;
      cycle();
    end
    wr_en = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flit_in = '0;
    repeat (2) cycle();
    rst = 1'b0;
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", buf_empty0); end
    checks++; if (buf_full0 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", buf_full0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
    checks++; if (count0 !== 13'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count0); end
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow0); end
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    f = mk_flit(1'b1, 4'b1111, 3'd0, 32'hA5A5_0001);
    flit_in = f; wr_en = 1'b1;
    cycle();
    wr_en = 1'b0;
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL single_in_s1_empty: got %b expected 1", buf_empty0); end
    cycle();
    checks++; if (buf_empty0 !== 1'b0) begin errors++; $display("FAIL single_empty: got %b expected 0", buf_empty0); end
    checks++; if (dout0[84:82] !== 3'd3) begin errors++; $display("FAIL single_children: got %0d expected 3", dout0[84:82]); end
    checks++; if (dout0[81:0] !== f) begin errors++; $display("FAIL single_flit: got %h expected %h", dout0[81:0], f); end
    checks++; if (count0 !== 13'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count0); end
    rd_en = 1'b1;
    cycle();
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b expected 1", buf_empty0); end
    // Pop on an empty FIFO must not underflow the counter
    cycle();
    rd_en = 1'b0;
    checks++; if (count0 !== 13'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", count0); end
  endtask

  task automatic test_invalid();
    flit_in = mk_flit(1'b0, 4'b1111, 3'd0, 32'h0BAD_0000); wr_en = 1'b1;
    cycle();
    flit_in = mk_flit(1'b1, 4'b1111, 3'd0, 32'h0BAD_0001); wr_en = 1'b0;
    repeat (2) cycle();
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL invalid_empty: got %b expected 1", buf_empty0); end
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL invalid_overflow: got %b expected 0", overflow0); end
  endtask

  task automatic test_children();
    logic [FW-1:0] fl [4];
    logic [2:0]    e6 [4];
    logic [2:0]    e0 [4];
    fl[0] = mk_flit(1'b1, 4'b1111, 3'd2, 32'h0000_C002); e6[0] = 3'd2; e0[0] = 3'd1;
    fl[1] = mk_flit(1'b1, 4'b1111, 3'd5, 32'h0000_C005); e6[1] = 3'd0; e0[1] = 3'd0;
    fl[2] = mk_flit(1'b1, 4'b1111, 3'd6, 32'h0000_C006); e6[2] = 3'd3; e0[2] = 3'd1;
    fl[3] = mk_flit(1'b1, 4'b0111, 3'd6, 32'h0000_B006); e6[3] = 3'd0; e0[3] = 3'd0;
    for (int k = 0; k < 4; k++) begin
      flit_in = fl[k]; wr_en = 1'b1;
      cycle();
    end
    wr_en = 1'b0;
    cycle();
    checks++; if (count6 !== 13'd4) begin errors++; $display("FAIL children_count: got %0d expected 4", count6); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout6[84:82] !== e6[k]) begin errors++; $display("FAIL children_rank6_%0d: got %0d expected %0d", k, dout6[84:82], e6[k]); end
      checks++; if (dout0[84:82] !== e0[k]) begin errors++; $display("FAIL children_rank0_%0d: got %0d expected %0d", k, dout0[84:82], e0[k]); end
      checks++; if (dout6[81:0] !== fl[k]) begin errors++; $display("FAIL children_flit_%0d: got %h expected %h", k, dout6[81:0], fl[k]); end
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      flit_in = mk_flit(1'b1, 4'b0001, 3'd1, 32'(i)); wr_en = 1'b1;
      cycle();
      if (i == 14) begin
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL ready_at_14: got %b expected 1", in_ready0); end
      end
      if (i == 15) begin
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL ready_at_15: got %b expected 0", in_ready0); end
      end
    end
    wr_en = 1'b0;
    cycle();
    checks++; if (buf_full0 !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", buf_full0); end
    checks++; if (count0 !== 13'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", count0); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready0); end
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL full_no_overflow: got %b expected 0", overflow0); end
    flit_in = mk_flit(1'b1, 4'b0001, 3'd1, 32'd16); wr_en = 1'b1;
    cycle();
    wr_en = 1'b0;
    cycle();
    checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b expected 1", overflow0); end
    checks++; if (count0 !== 13'd16) begin errors++; $display("FAIL drop_count: got %0d expected 16", count0); end
    checks++; if (dout0[31:0] !== 32'd0) begin errors++; $display("FAIL drop_head: got %0d expected 0", dout0[31:0]); end
  endtask

  task automatic test_full_pop_and_reset();
    do_reset();
    fill16();
    flit_in = mk_flit(1'b1, 4'b0001, 3'd1, 32'd99); wr_en = 1'b1;
    cycle();
    wr_en = 1'b0; rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    checks++; if (count0 !== 13'd15) begin errors++; $display("FAIL fullpop_count: got %0d expected 15", count0); end
    checks++; if (overflow0 !== 1'b1) begin errors++; $display("FAIL fullpop_overflow: got %b expected 1", overflow0); end
    checks++; if (dout0[31:0] !== 32'd1) begin errors++; $display("FAIL fullpop_head: got %0d expected 1", dout0[31:0]); end
    checks++; if (buf_full0 !== 1'b0) begin errors++; $display("FAIL fullpop_full: got %b expected 0", buf_full0); end
    rd_en = 1'b1;
    repeat (10) cycle();
    rd_en = 1'b0;
    checks++; if (count0 !== 13'd5) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 5", count0); end
    // Strobes during reset must be ignored
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    flit_in = mk_flit(1'b1, 4'b1111, 3'd0, 32'hDEAD_0000);
    cycle();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count0 !== 13'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count0); end
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", buf_empty0); end
    checks++; if (overflow0 !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b expected 0", overflow0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready0); end
    cycle();
    checks++; if (buf_empty0 !== 1'b1) begin errors++; $display("FAIL midrst_s1_discard: got %b expected 1", buf_empty0); end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp_f;
    do_reset();
    for (int i = 0; i < 43; i++) begin
      flit_in = mk_flit(1'b1, 4'b0011, 3'(i), 32'h1000 + 32'(i));
      wr_en   = 1'b1;
      rd_en   = (i >= 3);
      if (i >= 3) begin
        exp_f = mk_flit(1'b1, 4'b0011, 3'(i - 3), 32'h1000 + 32'(i - 3));
        checks++; if (dout0[81:0] !== exp_f) begin errors++; $display("FAIL stream_order_%0d: got %h expected %h", i - 3, dout0[81:0], exp_f); end
        checks++; if (count0 !== 13'd2) begin errors++; $display("FAIL stream_count_%0d: got %0d expected 2", i, count0); end
      end
      cycle();
    end
    wr_en = 1'b0; rd_en = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_invalid();
    test_children();
    test_full();
    test_full_pop_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
